// File: rtl/ff_convert_pkg.sv
// ============================================================================
// Module : ff_convert_pkg
// Brief  : Shared mode encodings for the ff_convert flip-flop bank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ff_convert_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } ff_mode_t;

endpackage : ff_convert_pkg

`default_nettype wire

// File: rtl/ff_convert_cell.sv
// ============================================================================
// Module : ff_convert_cell
// Brief  : One runtime-configurable SR/JK/D/T flip-flop bit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ff_convert_cell
  import ff_convert_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  ff_mode_t mode,
  input  logic     a,
  input  logic     b,
  output logic     q,
  output logic     illegal_hit
);

  logic q_q;
  logic q_d;

  // b is only read in SR/JK so an undriven b cannot leak X in D/T modes.
  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        MODE_SR: begin
          if (a && !b)      q_d = 1'b1;
          else if (!a && b) q_d = 1'b0;
        end
        MODE_JK: begin
          if (a && b)       q_d = ~q_q;
          else if (a)       q_d = 1'b1;
          else if (b)       q_d = 1'b0;
        end
        MODE_D:             q_d = a;
        MODE_T: begin
          if (a)            q_d = ~q_q;
        end
        default:            q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RESET_BIT;
    else        q_q <= q_d;
  end

  assign q           = q_q;
  assign illegal_hit = en && (mode == MODE_SR) && a && b;

endmodule : ff_convert_cell

`default_nettype wire

// File: rtl/ff_convert_bank.sv
// ============================================================================
// Module : ff_convert_bank
// Brief  : WIDTH-bit bank of SR/JK/D/T flip-flops; optional sticky S=R=1
//          detection enabled by macro FF_ILLEGAL_DETECT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ff_convert_bank
  import ff_convert_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             illegal_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_b,
  output logic             illegal,
  output logic [WIDTH-1:0] illegal_bits
);

  ff_mode_t         w_mode;
  logic [WIDTH-1:0] w_hit;

  assign w_mode = ff_mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_convert_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .mode        (w_mode),
      .a           (a[i]),
      .b           (b[i]),
      .q           (q[i]),
      .illegal_hit (w_hit[i])
    );
  end

  assign q_b = ~q;

`ifdef FF_ILLEGAL_DETECT_EN
  logic             illegal_q;
  logic             illegal_d;
  logic [WIDTH-1:0] illegal_bits_q;
  logic [WIDTH-1:0] illegal_bits_d;

  // A fresh S=R=1 on the clearing edge defeats the clear entirely.
  always_comb begin
    illegal_bits_d = illegal_bits_q | w_hit;
    illegal_d      = illegal_q | (|w_hit);
    if (illegal_clr && (w_hit == '0)) begin
      illegal_bits_d = '0;
      illegal_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q      <= 1'b0;
      illegal_bits_q <= '0;
    end else begin
      illegal_q      <= illegal_d;
      illegal_bits_q <= illegal_bits_d;
    end
  end

  assign illegal      = illegal_q;
  assign illegal_bits = illegal_bits_q;
`else
  logic w_unused;
  assign w_unused     = ^{illegal_clr, w_hit};
  assign illegal      = 1'b0;
  assign illegal_bits = '0;
`endif

endmodule : ff_convert_bank

`default_nettype wire

// File: tb/tb_ff_convert_bank.sv
// ============================================================================
// Module : tb_ff_convert_bank
// Brief  : Scoreboard bench for ff_convert_bank (WIDTH=4, RESET_VAL=0).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ff_convert_bank;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         en = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         illegal_clr = 1'b0;
  logic [W-1:0] q;
  logic [W-1:0] q_b;
  logic         illegal;
  logic [W-1:0] illegal_bits;

  ff_convert_bank #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .en           (en),
    .a            (a),
    .b            (b),
    .illegal_clr  (illegal_clr),
    .q            (q),
    .q_b          (q_b),
    .illegal      (illegal),
    .illegal_bits (illegal_bits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         ill;
    logic [W-1:0] ib;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] m_q  = '0;
  logic         m_ill = 1'b0;
  logic [W-1:0] m_ib = '0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rules, one bit at a time.
  function automatic logic [W-1:0] next_q(input logic [W-1:0] q0, input logic [1:0] md,
                                          input logic [W-1:0] aa, input logic [W-1:0] bb);
    logic [W-1:0] r;
    r = q0;
    for (int i = 0; i < W; i++) begin
      case (md)
        2'b00: begin
          if (aa[i] === 1'b1 && bb[i] === 1'b0) r[i] = 1'b1;
          if (aa[i] === 1'b0 && bb[i] === 1'b1) r[i] = 1'b0;
        end
        2'b01: begin
          if (aa[i] === 1'b1 && bb[i] === 1'b0) r[i] = 1'b1;
          if (aa[i] === 1'b0 && bb[i] === 1'b1) r[i] = 1'b0;
          if (aa[i] === 1'b1 && bb[i] === 1'b1) r[i] = ~q0[i];
        end
        2'b10: r[i] = aa[i];
        default: if (aa[i]) r[i] = ~q0[i];
      endcase
    end
    return r;
  endfunction

  task automatic drive(input logic e, input logic [1:0] md, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic clr);
    logic [W-1:0] hit;
    exp_t         x;
    @(negedge clk);
    en = e; mode = md; a = aa; b = bb; illegal_clr = clr;
    if (e) m_q = next_q(m_q, md, aa, bb);
    hit = (e && md == 2'b00) ? (aa & bb) : '0;
`ifdef FF_ILLEGAL_DETECT_EN
    if (clr && hit == '0) begin
      m_ib = '0; m_ill = 1'b0;
    end else begin
      m_ib = m_ib | hit; m_ill = m_ill | (|hit);
    end
`else
    m_ib = '0; m_ill = 1'b0;
`endif
    x.q = m_q; x.ill = m_ill; x.ib = m_ib;
    sb.push_back(x);
  endtask

  // Monitor: the bank updates every edge, so each edge with a pending entry is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q", q, e.q);
        chk("q_b", q_b, ~e.q);
        chk("illegal", {3'b000, illegal}, {3'b000, e.ill});
        chk("illegal_bits", illegal_bits, e.ib);
      end
    end
  end

  initial begin
    logic [1:0]   seq [4];
    logic [1:0]   md;
    logic [W-1:0] ra, rb;
    int           waited;
    seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b00; seq[3] = 2'b10;

    #2;
    chk("por_q", q, 4'b0000);
    chk("por_q_b", q_b, 4'b1111);
    chk("por_illegal_bits", illegal_bits, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle from q=1111.
    drive(1'b1, 2'b10, 4'b1111, 4'b0000, 1'b0);
    @(posedge clk);
    #2;
    en = 1'b0; illegal_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", q, 4'b0000);
    chk("async_rst_q_b", q_b, 4'b1111);
    chk("async_rst_illegal", {3'b000, illegal}, 4'b0000);
    m_q = '0; m_ill = 1'b0; m_ib = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed patterns.
    drive(1'b1, 2'b10, 4'b0101, 4'b0000, 1'b0);
    drive(1'b1, 2'b01, 4'b1100, 4'b1010, 1'b0);
    drive(1'b1, 2'b10, 4'b0000, 4'b1111, 1'b0);
    drive(1'b1, 2'b00, 4'b0011, 4'b0001, 1'b0);
    drive(1'b1, 2'b00, 4'b1000, 4'b1000, 1'b1);
    drive(1'b1, 2'b00, 4'b0000, 4'b0000, 1'b1);
    drive(1'b0, 2'b00, 4'b1111, 4'b1111, 1'b0);
    drive(1'b1, 2'b10, 4'b1011, 4'bxxxx, 1'b0);
    drive(1'b1, 2'b11, 4'b1111, 4'bxxxx, 1'b0);
    drive(1'b0, 2'b10, 4'b1111, 4'b0000, 1'b0);
    drive(1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0);

    // Random stimulus with the mode rotating JK -> T -> SR -> D.
    for (int i = 0; i < 200; i++) begin
      md = seq[i % 4];
      ra = 4'($urandom);
      rb = 4'($urandom);
      if (md[1] && $urandom_range(0, 1) == 0) rb = 4'bxxxx;
      drive($urandom_range(0, 7) != 0, md, ra, rb, $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    en = 1'b0; illegal_clr = 1'b0; b = '0;
    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ff_convert_bank

`default_nettype wire
